btn_gesture: RTL and testbench
==============================

BTN_GESTURE -- requirements
Module: btn_gesture

Interface
REQ-001 Parameter LONG_CYCLES, default 50000000, is the hold length in clk cycles that qualifies a long press; legal range >= 2.
REQ-002 Parameter GAP_CYCLES, default 25000000, is the maximum release-to-repress gap in clk cycles that qualifies a double click; legal range >= 2.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port btn_state  input  1  debounced button level from the upstream debouncer; 1 = held.
REQ-006 Port single_click  output  1  one-cycle pulse per qualified single click.
REQ-007 Port double_click  output  1  one-cycle pulse per qualified double click.
REQ-008 Port long_press  output  1  one-cycle pulse per qualified long press.
REQ-009 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 All outputs SHALL be registered; btn_state SHALL be sampled only on rising clk edges.
REQ-011 The FSM SHALL have the states IDLE, PRESS1, GAP and WAIT_REL, plus one internal counter wide enough for max(LONG_CYCLES, GAP_CYCLES)-1.
REQ-012 IDLE: btn_state=1 SHALL move to PRESS1 with counter=0; otherwise remain in IDLE.
REQ-013 PRESS1, btn_state=1, counter<LONG_CYCLES-1: counter SHALL increment.
REQ-014 PRESS1, btn_state=1, counter=LONG_CYCLES-1: long_press SHALL pulse and the FSM SHALL go to WAIT_REL; long_press is therefore high in the cycle after edge E0+LONG_CYCLES, where E0 is the edge entering PRESS1.
REQ-015 PRESS1, btn_state=0, any counter value including LONG_CYCLES-1: the FSM SHALL go to GAP with counter=0 and emit no pulse.
REQ-016 GAP, btn_state=1, any counter value: double_click SHALL pulse and the FSM SHALL go to WAIT_REL. A press sampled on the timeout edge wins over the timeout.
REQ-017 GAP, btn_state=0, counter<GAP_CYCLES-1: counter SHALL increment.
REQ-018 GAP, btn_state=0, counter=GAP_CYCLES-1: single_click SHALL pulse and the FSM SHALL go to IDLE.
REQ-019 WAIT_REL: btn_state=0 SHALL move to IDLE with no pulse; otherwise remain. A long hold SHALL produce exactly one long_press and no further events until release.
REQ-020 At most one of single_click/double_click/long_press SHALL be high in any cycle; each pulse SHALL last exactly one cycle.
REQ-021 busy SHALL be registered alongside the state and be 1 exactly when the registered state is not IDLE.

Reset
REQ-022 rst=1 at a rising edge SHALL force state=IDLE, counter=0, and all outputs to 0 in the following cycle, overriding any transition or pulse due on that edge.
REQ-023 A reset mid-gesture SHALL discard the gesture; no pulse SHALL be emitted for it.
REQ-024 If btn_state=1 on the first edge after rst deasserts, the FSM SHALL treat it as a new press and enter PRESS1.

Verification (LONG_CYCLES=16, GAP_CYCLES=8)
REQ-025 Hold btn 5 cycles, release, keep low -> single_click high for 1 cycle exactly 8 cycles after the GAP-entry edge; busy drops the same cycle; no other pulse.
REQ-026 Hold 5, release 3, hold again 4, release -> double_click high for 1 cycle after the second press is sampled; busy returns to 0 one cycle after release; no single_click.
REQ-027 Hold 40 cycles then release -> exactly one long_press, 16 cycles after the PRESS1-entry edge; nothing on release or during the following 20 idle cycles.
REQ-028 Boundaries: release on the edge where counter=15 -> GAP, no long_press. Repress sampled on the edge where GAP counter=7 -> double_click, not single_click.
REQ-029 Assert rst for 1 cycle in mid-PRESS1 and again in mid-GAP -> next cycle busy=0 and all outputs 0; no pulse for the aborted gesture. Button held through rst release -> PRESS1 entered.
REQ-030 Throughout every scenario, check that no two event outputs are high together and that every pulse width is exactly 1.

Source files
------------

// File: rtl/btn_gesture.sv
// Button gesture classifier: turns a debounced button level into single-click,
// double-click and long-press pulses, plus a busy flag while a gesture is open.
module btn_gesture #(
    parameter int unsigned LONG_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES  = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_state,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int unsigned CntMax = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPress1,
        StGap,
        StWaitRel
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            single_d, double_d, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            single_click <= single_d;
            double_click <= double_d;
            long_press   <= long_d;
            busy         <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (btn_state) begin
                    state_d = StPress1;
                    cnt_d   = '0;
                end
            end
            StPress1: begin
                if (!btn_state) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    state_d = StWaitRel;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                // A repress on the timeout edge still counts as a double click.
                if (btn_state) begin
                    state_d = StWaitRel;
                end else if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitRel: begin
                if (!btn_state) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        single_d = (state_q == StGap) && !btn_state && (cnt_q == GapLast);
        double_d = (state_q == StGap) && btn_state;
        long_d   = (state_q == StPress1) && btn_state && (cnt_q == LongLast);
    end

endmodule

// File: tb/tb_btn_gesture.sv
// Bench for btn_gesture: directed gesture scenarios then random press/release
// runs, every cycle compared against a timestamp-based reference model.
module tb_btn_gesture;

    localparam int unsigned LONG = 16;
    localparam int unsigned GAP  = 8;

    logic clk;
    logic rst;
    logic btn_state;
    logic single_click, double_click, long_press, busy;

    btn_gesture #(
        .LONG_CYCLES(LONG),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_state   (btn_state),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Model: edge index where the press began / the release began, or -1.
    int press_edge = -1;
    int rel_edge   = -1;
    bit latched    = 1'b0;
    bit e_s, e_d, e_l;

    int cnt_s = 0, cnt_d = 0, cnt_l = 0;
    logic prev_s = 1'b0, prev_d = 1'b0, prev_l = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit b, input bit r);
        e_s = 1'b0;
        e_d = 1'b0;
        e_l = 1'b0;
        if (r) begin
            press_edge = -1;
            rel_edge   = -1;
            latched    = 1'b0;
        end else if (latched) begin
            if (!b) latched = 1'b0;
        end else if (press_edge >= 0) begin
            if (!b) begin
                rel_edge   = n;
                press_edge = -1;
            end else if (n - press_edge == int'(LONG)) begin
                e_l        = 1'b1;
                latched    = 1'b1;
                press_edge = -1;
            end
        end else if (rel_edge >= 0) begin
            if (b) begin
                e_d      = 1'b1;
                latched  = 1'b1;
                rel_edge = -1;
            end else if (n - rel_edge == int'(GAP)) begin
                e_s      = 1'b1;
                rel_edge = -1;
            end
        end else if (b) begin
            press_edge = n;
        end
    endtask

    task automatic check_outputs();
        logic exp_busy;
        exp_busy = (press_edge >= 0) || (rel_edge >= 0) || latched;
        chk("single_click", single_click, e_s);
        chk("double_click", double_click, e_d);
        chk("long_press", long_press, e_l);
        chk("busy", busy, exp_busy);
        chk("one_hot", ($countones({single_click, double_click, long_press}) <= 1), 1'b1);
        chk("pulse_width", (prev_s & single_click) | (prev_d & double_click)
            | (prev_l & long_press), 1'b0);
        cnt_s += int'(single_click === 1'b1);
        cnt_d += int'(double_click === 1'b1);
        cnt_l += int'(long_press === 1'b1);
        prev_s = single_click;
        prev_d = double_click;
        prev_l = long_press;
    endtask

    task automatic cycle(input logic b, input logic r);
        btn_state = b;
        rst       = r;
        @(posedge clk);
        model(b, r);
        n++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input logic b, input int len);
        for (int i = 0; i < len; i++) cycle(b, 1'b0);
    endtask

    task automatic expect_counts(input string tag, input int bs, input int bd, input int bl,
                                 input int xs, input int xd, input int xl);
        chk_int({tag, "_single"}, cnt_s - bs, xs);
        chk_int({tag, "_double"}, cnt_d - bd, xd);
        chk_int({tag, "_long"}, cnt_l - bl, xl);
    endtask

    initial begin
        int bs, bd, bl;
        btn_state = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("reset_busy", busy, 1'b0);

        // Single click
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, 5);
        hold(1'b0, 15);
        expect_counts("single", bs, bd, bl, 1, 0, 0);

        // Double click
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 4);
        hold(1'b0, 12);
        expect_counts("double", bs, bd, bl, 0, 1, 0);

        // Long press held well past the threshold
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, 40);
        hold(1'b0, 20);
        expect_counts("long", bs, bd, bl, 0, 0, 1);

        // Release on the last press count: no long press, ends as a single click
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, LONG);
        hold(1'b0, 12);
        expect_counts("long_edge", bs, bd, bl, 1, 0, 0);

        // One cycle longer reaches the long press
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, LONG + 1);
        hold(1'b0, 4);
        expect_counts("long_min", bs, bd, bl, 0, 0, 1);

        // Repress on the timeout edge wins
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, 3);
        hold(1'b0, GAP);
        hold(1'b1, 2);
        hold(1'b0, 4);
        expect_counts("gap_edge", bs, bd, bl, 0, 1, 0);

        // One cycle later the single click has already fired
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, 3);
        hold(1'b0, GAP + 1);
        hold(1'b1, 2);
        hold(1'b0, 12);
        expect_counts("gap_late", bs, bd, bl, 2, 0, 0);

        // Reset mid-press with button held through, then reset mid-gap
        bs = cnt_s; bd = cnt_d; bl = cnt_l;
        hold(1'b1, 6);
        cycle(1'b1, 1'b1);
        chk("rst_press_busy", busy, 1'b0);
        hold(1'b1, 3);
        chk("rst_repress_busy", busy, 1'b1);
        hold(1'b0, 3);
        cycle(1'b0, 1'b1);
        chk("rst_gap_busy", busy, 1'b0);
        hold(1'b0, 15);
        expect_counts("rst_abort", bs, bd, bl, 0, 0, 0);

        // Random press/release runs with occasional resets
        for (int k = 0; k < 150; k++) begin
            hold(1'b1, int'($urandom_range(1, 22)));
            if ($urandom_range(0, 9) == 0) cycle(1'b1, 1'b1);
            hold(1'b0, int'($urandom_range(1, 12)));
            if ($urandom_range(0, 14) == 0) cycle(1'b0, 1'b1);
        end
        hold(1'b0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
